// File: rtl/rle_pkg.sv
// Shared definitions for the row RLE compressor / decompressor pair.
// Token format: [CNT][Y][C]; CNT==SYNC_BYTE is a row-sync marker.
package rle_pkg;

    typedef enum logic [1:0] {
        S_CNT,
        S_Y,
        S_C,
        S_EMIT
    } rle_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h00;
    localparam int         MAX_RUN   = 255;
    localparam int         RUN_W     = $clog2(MAX_RUN + 1);

    // Pixel layout {Y, C}
    localparam int Y_MSB = 15;
    localparam int Y_LSB = 8;
    localparam int C_MSB = 7;
    localparam int C_LSB = 0;

    function automatic int col_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/rle_col_counter.sv
// Column position within a RowPixelWidth-pixel row, with explicit wrap,
// row-start / row-done flags and a synchronous clear for row-sync markers.
module rle_col_counter
    import rle_pkg::*;
#(
    parameter int RowPixelWidth = 640
) (
    input  logic CLK,
    input  logic RST,
    input  logic advance,
    input  logic sync_clr,
    output logic row_start,
    output logic row_done
);

    localparam int ColW = col_width(RowPixelWidth);

    logic [ColW-1:0] col;
    logic            at_end;

    // Wrap on the exact last column so non-power-of-two widths work.
    assign at_end = (col == ColW'(RowPixelWidth - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            col <= '0;
        end else if (sync_clr) begin
            col <= '0;
        end else if (advance) begin
            col <= at_end ? '0 : col + 1'b1;
        end
    end

    assign row_start = (col == '0);
    assign row_done  = advance && at_end;

endmodule

// File: rtl/rle_decompressor.sv
// Expands [CNT][Y][C] run tokens from a FWFT byte FIFO into {Y,C} pixels.
// Define RLE_DECOMP_CHECK_EN to flag misplaced sync markers and clip row-crossing runs.
module rle_decompressor
    import rle_pkg::*;
#(
    parameter int RowPixelWidth = 640,
    parameter int PixelSize     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [7:0]           i_byte,
    input  logic                 i_byte_valid,
    output logic                 o_byte_ready,
    output logic [PixelSize-1:0] o_pixel,
    output logic                 o_pixel_valid,
    input  logic                 i_pixel_ready,
    output logic                 o_row_start,
    output logic                 o_row_done,
    output logic                 o_err
);

    rle_state_t       state, state_d;
    logic [RUN_W-1:0] run_left;
    logic [7:0]       y_q;
    logic             byte_acc, pix_acc, sync_hit, row_start, clip;

    // NOTE: gated by RST so the FIFO is never popped while the FSM is held in reset.
    assign o_byte_ready = !RST && (state != S_EMIT);
    assign byte_acc     = i_byte_valid && o_byte_ready;
    assign pix_acc      = o_pixel_valid && i_pixel_ready;
    assign sync_hit     = byte_acc && (state == S_CNT) && (i_byte == SYNC_BYTE);

    rle_col_counter #(
        .RowPixelWidth(RowPixelWidth)
    ) u_col (
        .CLK      (CLK),
        .RST      (RST),
        .advance  (pix_acc),
        .sync_clr (sync_hit),
        .row_start(row_start),
        .row_done (o_row_done)
    );

    assign o_row_start = o_pixel_valid && row_start;

    always_comb begin
        state_d = state;
        unique case (state)
            S_CNT:   if (byte_acc && i_byte != SYNC_BYTE) state_d = S_Y;
            S_Y:     if (byte_acc) state_d = S_C;
            S_C:     if (byte_acc) state_d = S_EMIT;
            S_EMIT:  if (pix_acc && (run_left == RUN_W'(1) || clip)) state_d = S_CNT;
            default: state_d = S_CNT;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_CNT;
            run_left      <= '0;
            y_q           <= '0;
            o_pixel       <= '0;
            o_pixel_valid <= 1'b0;
        end else begin
            state         <= state_d;
            o_pixel_valid <= (state_d == S_EMIT);
            if (byte_acc) begin
                case (state)
                    S_CNT:   run_left <= i_byte;
                    S_Y:     y_q      <= i_byte;
                    S_C: begin
                        o_pixel[Y_MSB:Y_LSB] <= y_q;
                        o_pixel[C_MSB:C_LSB] <= i_byte;
                    end
                    default: ;
                endcase
            end else if (pix_acc) begin
                run_left <= clip ? '0 : run_left - 1'b1;
            end
        end
    end

`ifdef RLE_DECOMP_CHECK_EN
    // A run still owing pixels at the row end is cut short.
    assign clip = o_row_done && (run_left != RUN_W'(1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            o_err <= 1'b0;
        end else if ((sync_hit && !row_start) || clip) begin
            o_err <= 1'b1;
        end
    end
`else
    assign clip  = 1'b0;
    assign o_err = 1'b0;
`endif

endmodule
